// File: rtl/port_uart_pkg.sv
// Shared types and port-word bit positions for the port_uart peripheral.
package port_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // port_out (CPU -> peripheral)
  localparam int TX_BYTE_LSB = 0;
  localparam int TX_REQ      = 8;
  localparam int RX_ACK      = 12;

  // port_in (peripheral -> CPU)
  localparam int TX_ACK      = 8;
  localparam int TX_BUSY     = 9;
  localparam int RX_TOG      = 12;
  localparam int RX_OVR      = 13;
  localparam int RX_FERR     = 14;

endpackage

// File: rtl/port_uart_rx.sv
// 8N1 receiver: 2-flop synchronizer, falling-edge start detect, mid-bit sampling.
module port_uart_rx
  import port_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  output logic        frame_err_o,
  output uart_state_e state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic          sync1_q, sync2_q, prev_q;
  logic          fall;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;

  assign fall = prev_q & ~sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        // Line back high at mid start bit means it was a glitch.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          valid_d = sync2_q;
          ferr_d  = ~sync2_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_o      = shift_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign state_o     = state_q;

endmodule

// File: rtl/port_uart.sv
// UART bridged onto the CPU port pair: TX FSM, port_in register, RX sub-module.
module port_uart
  import port_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] port_out,
  output logic [31:0] port_in,
  input  logic        uart_rx,
  output logic        uart_tx,
  output uart_state_e dbg_tx_state_o,
  output uart_state_e dbg_rx_state_o
);

  // Handshake: both directions use toggle pairs. TX: CPU flips tx_req when a
  // new byte is on port_out[7:0]; the peripheral flips tx_ack once the stop
  // bit ends. RX: the peripheral flips rx_tog when a byte lands in port_in;
  // the CPU flips rx_ack to release it. A pair that differs means "pending".

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_e   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;
  logic          tx_ack_q, tx_ack_d;
  logic          tx_busy_q;
  logic          tx_bit_end;

  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_tog_q, rx_tog_d;
  logic          rx_ovr_q, rx_ovr_d;
  logic          rx_ferr_q, rx_ferr_d;
  logic          rx_ack_q;
  logic          ack_edge, pending;

  logic [7:0]    rx_byte;
  logic          rx_valid, rx_ferr;
  uart_state_e   rx_state;

  logic          unused_port_out;
  assign unused_port_out = ^{port_out[31:13], port_out[11:9]};

  port_uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .rx_i       (uart_rx),
    .byte_o     (rx_byte),
    .valid_o    (rx_valid),
    .frame_err_o(rx_ferr),
    .state_o    (rx_state)
  );

  assign tx_bit_end = (tx_cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
      tx_ack_q   <= 1'b0;
      tx_busy_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      tx_ack_q   <= tx_ack_d;
      tx_busy_q  <= (tx_state_d != IDLE);
    end
  end

  // uart_tx is driven from tx_line_q, so each line value is set one state early.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_ack_d   = tx_ack_q;
    unique case (tx_state_q)
      IDLE: begin
        if (port_out[TX_REQ] != tx_ack_q) begin
          tx_state_d = START;
          tx_shift_d = port_out[TX_BYTE_LSB +: 8];
          tx_cnt_d   = '0;
          tx_line_d  = 1'b0;
        end
      end
      START: begin
        if (tx_bit_end) begin
          tx_state_d = DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = STOP;
            tx_line_d  = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (tx_bit_end) begin
          tx_state_d = IDLE;
          tx_cnt_d   = '0;
          tx_ack_d   = ~tx_ack_q;
        end else begin
          tx_cnt_d = tx_cnt_q + CW'(1);
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_byte_q <= '0;
      rx_tog_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
      rx_ferr_q <= 1'b0;
      rx_ack_q  <= 1'b0;
    end else begin
      rx_byte_q <= rx_byte_d;
      rx_tog_q  <= rx_tog_d;
      rx_ovr_q  <= rx_ovr_d;
      rx_ferr_q <= rx_ferr_d;
      rx_ack_q  <= port_out[RX_ACK];
    end
  end

  // Clears from an ack edge come first so a same-cycle flag set wins.
  always_comb begin
    ack_edge  = port_out[RX_ACK] ^ rx_ack_q;
    pending   = rx_tog_q ^ port_out[RX_ACK];
    rx_byte_d = rx_byte_q;
    rx_tog_d  = rx_tog_q;
    rx_ovr_d  = ack_edge ? 1'b0 : rx_ovr_q;
    rx_ferr_d = ack_edge ? 1'b0 : rx_ferr_q;
    if (rx_valid) begin
      if (!pending) begin
        rx_byte_d = rx_byte;
        rx_tog_d  = ~rx_tog_q;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
    if (rx_ferr) begin
      rx_ferr_d = 1'b1;
    end
  end

  always_comb begin
    port_in                        = '0;
    port_in[TX_BYTE_LSB +: 8]      = rx_byte_q;
    port_in[TX_ACK]                = tx_ack_q;
    port_in[TX_BUSY]               = tx_busy_q;
    port_in[RX_TOG]                = rx_tog_q;
    port_in[RX_OVR]                = rx_ovr_q;
    port_in[RX_FERR]               = rx_ferr_q;
  end

  assign uart_tx        = tx_line_q;
  assign dbg_tx_state_o = tx_state_q;
  assign dbg_rx_state_o = rx_state;

endmodule

// File: tb/tb_port_uart.sv
// Directed bench for port_uart at 16 clocks per bit.
module tb_port_uart;
  import port_uart_pkg::*;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] port_out;
  logic [31:0] port_in;
  logic        uart_rx;
  logic        uart_tx;
  uart_state_e dbg_tx_state;
  uart_state_e dbg_rx_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  port_uart #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .port_out      (port_out),
    .port_in       (port_in),
    .uart_rx       (uart_rx),
    .uart_tx       (uart_tx),
    .dbg_tx_state_o(dbg_tx_state),
    .dbg_rx_state_o(dbg_rx_state)
  );

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- check / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = fr[i];
      tick(CPB);
    end
    uart_rx = 1'b1;
  endtask

  task automatic capture_tx(output logic [7:0] b, output logic stop_bit);
    int waited;
    waited   = 0;
    b        = '0;
    stop_bit = 1'b0;
    while (uart_tx !== 1'b0 && waited < 50) begin
      tick(1);
      waited++;
    end
    check("tx_start_seen", {31'b0, uart_tx}, 32'd0);
    tick(CPB / 2);
    check("tx_start_mid", {31'b0, uart_tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick(CPB);
      b[i] = uart_tx;
    end
    tick(CPB);
    stop_bit = uart_tx;
  endtask

  task automatic wait_ack(input logic val);
    int waited;
    waited = 0;
    while (port_in[8] !== val && waited < 400) begin
      tick(1);
      waited++;
    end
    check("tx_ack_wait", {31'b0, port_in[8]}, {31'b0, val});
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    logic [9:0] pat;
    logic [7:0] got_b;
    logic       got_stop;
    logic [9:0] fr;

    rst      = 1'b1;
    port_out = '0;
    uart_rx  = 1'b1;
    tick(3);
    check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("rst_port_in", port_in, 32'h0);
    check("rst_tx_state", 32'(dbg_tx_state), 32'(IDLE));
    check("rst_rx_state", 32'(dbg_rx_state), 32'(IDLE));

    // TX 0xA5; byte field changes mid-frame without a new request
    rst      = 1'b0;
    port_out = 32'h0000_01A5;
    tick(1);
    check("tx_start_low", {31'b0, uart_tx}, 32'd0);
    check("tx_busy_set", {31'b0, port_in[9]}, 32'd1);
    pat = 10'b11_0100_1010;
    tick(CPB / 2);
    for (int i = 0; i < 10; i++) begin
      check("tx_a5_bit", {31'b0, uart_tx}, {31'b0, pat[i]});
      if (i == 2) port_out = 32'h0000_013C;
      if (i < 9) tick(CPB);
    end
    tick(CPB / 2 - 1);
    check("tx_ack_early", {31'b0, port_in[8]}, 32'd0);
    check("tx_busy_early", {31'b0, port_in[9]}, 32'd1);
    tick(1);
    check("tx_ack_160", {31'b0, port_in[8]}, 32'd1);
    check("tx_busy_160", {31'b0, port_in[9]}, 32'd0);

    port_out = 32'h0000_003C;
    capture_tx(got_b, got_stop);
    check("tx_3c_byte", {24'b0, got_b}, 32'h3C);
    check("tx_3c_stop", {31'b0, got_stop}, 32'd1);
    wait_ack(1'b0);
    check("tx_idle_word", port_in, 32'h0);

    // RX clean byte
    tick(4);
    exp_q.push_back(8'h5A);
    send_rx(8'h5A, 1'b1);
    check("rx_5a_byte", {24'b0, port_in[7:0]}, {24'b0, exp_q.pop_front()});
    check("rx_5a_word", port_in, 32'h0000_105A);

    // RX overrun
    port_out[12] = ~port_out[12];
    tick(4);
    exp_q.push_back(8'h11);
    send_rx(8'h11, 1'b1);
    check("rx_11_byte", {24'b0, port_in[7:0]}, {24'b0, exp_q.pop_front()});
    check("rx_11_word", port_in, 32'h0000_0011);
    tick(4);
    send_rx(8'h22, 1'b1);
    check("rx_ovr_word", port_in, 32'h0000_2011);
    port_out[12] = ~port_out[12];
    tick(1);
    check("rx_ovr_clear", port_in, 32'h0000_0011);

    // RX framing error, then clear with two ack edges
    tick(4);
    send_rx(8'h77, 1'b0);
    check("rx_ferr_word", port_in, 32'h0000_4011);
    port_out[12] = ~port_out[12];
    tick(1);
    check("rx_ferr_clear", port_in, 32'h0000_0011);
    port_out[12] = ~port_out[12];
    tick(1);

    // RX glitch
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(30);
    check("rx_glitch_word", port_in, 32'h0000_0011);
    check("rx_glitch_state", 32'(dbg_rx_state), 32'(IDLE));

    // Reset during TX data bit 3 and RX data bit 5
    fr = {1'b1, 8'h66, 1'b0};
    for (int t = 0; t < 100; t++) begin
      uart_rx = fr[t / CPB];
      if (t == 30) port_out = 32'h0000_010F;
      tick(1);
    end
    check("pre_rst_tx_state", 32'(dbg_tx_state), 32'(DATA));
    check("pre_rst_rx_state", 32'(dbg_rx_state), 32'(DATA));
    rst     = 1'b1;
    uart_rx = 1'b1;
    tick(1);
    check("mid_rst_uart_tx", {31'b0, uart_tx}, 32'd1);
    check("mid_rst_port_in", port_in, 32'h0);
    rst = 1'b0;
    tick(1);
    check("rel_tx_start", {31'b0, uart_tx}, 32'd0);
    exp_q.push_back(8'h81);
    send_rx(8'h81, 1'b1);
    check("rx_81_byte", {24'b0, port_in[7:0]}, {24'b0, exp_q.pop_front()});
    check("rx_81_tog", {31'b0, port_in[12]}, 32'd1);
    check("rx_81_flags", {30'b0, port_in[14:13]}, 32'd0);
    wait_ack(1'b1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
